// File: rtl/disp_mon_pkg.sv
// disp_mon_pkg: shared constants and round-robin pick helper for the event monitor
package disp_mon_pkg;
   localparam int MODE_LEVEL = 0;
   localparam int MODE_EDGE = 1;
   localparam int MAX_CH = 32;
   // First requester after last, wrapping modulo n; returns last when nothing requests.
   function automatic int rr_pick(input logic [MAX_CH-1:0] req, input int last, input int n);
      int p;
      logic f;
      rr_pick = last;
      f = 1'b0;
      for (int k = 1; k <= MAX_CH; k++) begin
         p = (last + k) % n;
         if (!f && k <= n && req[p[4:0]]) begin
            rr_pick = p;
            f = 1'b1;
         end
      end
   endfunction
endpackage

// File: rtl/disp_mon_if.sv
// disp_mon_if: valid/ready record stream carrying {channel, timestamp, payload}
interface disp_mon_if #(parameter int CH_W = 2, TS_W = 16, DATA_W = 8);
   logic valid;
   logic ready;
   logic [CH_W-1:0] ch;
   logic [TS_W-1:0] ts;
   logic [DATA_W-1:0] data;
   modport master(output valid, ch, ts, data, input ready);
   modport slave(input valid, ch, ts, data, output ready);
endinterface

// File: rtl/disp_mon_fifo.sv
// disp_mon_fifo: generic synchronous FIFO; output reads zero while empty
module disp_mon_fifo #(parameter int WIDTH = 8, DEPTH = 4) (
   input  logic clk,
   input  logic rst_n,
   input  logic push,
   input  logic pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic full,
   output logic empty,
   output logic [$clog2(DEPTH):0] level
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] ONE = 1;
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0] wr, rd;
   logic do_push, do_pop;
   assign do_push = push && !full;
   assign do_pop = pop && !empty;
   assign level = wr - rd;
   assign full = level == (AW+1)'(DEPTH);
   assign empty = wr == rd;
   assign dout = empty ? '0 : mem[rd[AW-1:0]];
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wr <= '0;
         rd <= '0;
      end else begin
         if (do_push) wr <= wr + ONE;
         if (do_pop) rd <= rd + ONE;
      end
   always_ff @(posedge clk)
      if (do_push) mem[wr[AW-1:0]] <= din;
endmodule

// File: rtl/disp_event_monitor.sv
// disp_event_monitor: captures per-channel condition firings as timestamped records
module disp_event_monitor
   import disp_mon_pkg::*;
#(parameter int NUM_CH = 4, DATA_W = 8, TS_W = 16, DEPTH = 4, MODE = 0, DROP_W = 8) (
   input  logic clk,
   input  logic rst_n,
   input  logic [NUM_CH-1:0] en,
   input  logic [NUM_CH-1:0] cond,
   input  logic [NUM_CH*DATA_W-1:0] data,
   input  logic clear_drop,
   disp_mon_if.master out,
   output logic [$clog2(DEPTH):0] level,
   output logic [DROP_W-1:0] drop_cnt
);
   localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
   localparam int RW = CH_W + TS_W + DATA_W;
   localparam int SW = DROP_W + 6;
   logic [TS_W-1:0] ts;
   logic [NUM_CH-1:0] cond_q, pending, ev, gnt, drop;
   logic [TS_W-1:0] slot_ts [NUM_CH];
   logic [DATA_W-1:0] slot_data [NUM_CH];
   logic [CH_W-1:0] last, gnt_idx;
   logic gnt_v, full, empty;
   logic [SW-1:0] dsum;
   logic [DROP_W-1:0] drop_nxt;
   logic [RW-1:0] rec, dout;
   assign ev = (MODE == MODE_LEVEL) ? cond & en : cond & ~cond_q & en;
   assign gnt_v = |pending && !full;
   assign gnt_idx = CH_W'(rr_pick(MAX_CH'(pending), int'(last), NUM_CH));
   assign gnt = gnt_v ? NUM_CH'(1) << gnt_idx : '0;
   // A granted channel frees its slot this cycle, so a new event there re-arms instead of dropping.
   assign drop = ev & pending & ~gnt;
   assign dsum = SW'(drop_cnt) + SW'($countones(drop));
   assign drop_nxt = dsum > SW'({DROP_W{1'b1}}) ? '1 : dsum[DROP_W-1:0];
   assign rec = {gnt_idx, slot_ts[gnt_idx], slot_data[gnt_idx]};
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         ts <= '0;
         cond_q <= '0;
         pending <= '0;
         last <= CH_W'(NUM_CH - 1);
         drop_cnt <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            slot_ts[i] <= '0;
            slot_data[i] <= '0;
         end
      end else begin
         ts <= ts + TS_W'(1);
         cond_q <= cond;
         drop_cnt <= clear_drop ? '0 : drop_nxt;
         if (gnt_v) last <= gnt_idx;
         for (int i = 0; i < NUM_CH; i++)
            if (ev[i] && (!pending[i] || gnt[i])) begin
               pending[i] <= 1'b1;
               slot_ts[i] <= ts;
               slot_data[i] <= data[i*DATA_W +: DATA_W];
            end else if (gnt[i]) pending[i] <= 1'b0;
      end
   disp_mon_fifo #(.WIDTH(RW), .DEPTH(DEPTH)) u_fifo (
      .clk(clk),
      .rst_n(rst_n),
      .push(gnt_v),
      .pop(out.valid && out.ready),
      .din(rec),
      .dout(dout),
      .full(full),
      .empty(empty),
      .level(level)
   );
   assign out.valid = !empty;
   assign {out.ch, out.ts, out.data} = dout;
endmodule
